alu_issue_stage: RTL and testbench
==================================

Name: alu_issue_stage

Overview:
- ID→EX producer for the execute-stage ALU: turns decoded MIPS fields into the ALU control code plus operands.
- Registers the result as the ID/EX pipeline register driving EALUC/EXA/EXB.
- Performs operand forwarding, immediate/shamt packing, load-use stall with bubble insertion, and flush.

Parameters:
W, 32, datapath width (fixed at 32; shift packing and lui rely on it)

Ports:
CLK  in  1  clock; all state updates on rising edge
RESET  in  1  synchronous active-high reset
D_VALID  in  1  decode holds a valid instruction
D_OP  in  6  opcode
D_FUNCT  in  6  funct (R-type)
D_SHAMT  in  5  shift amount
D_IMM  in  16  immediate
D_RS, D_RT  in  5 each  source register numbers
D_RD  in  5  R-type destination
D_RSV, D_RTV  in  32 each  register-file read values
M_WE, M_DEST, M_VAL  in  1/5/32  EX/MEM writeback forward source
W_WE, W_DEST, W_VAL  in  1/5/32  MEM/WB writeback forward source
X_HOLD  in  1  downstream stall: hold ID/EX register
FLUSH  in  1  replace next ID/EX contents with bubble
D_STALL  out  1  combinational: decode must hold its instruction this cycle
EVALID  out  1  registered: EX slot holds a real instruction
EALUC  out  4  registered ALU control code
EXA, EXB  out  32 each  registered ALU operands
E_DEST  out  5  registered destination register (0 = no write)
E_LOAD  out  1  registered: EX instruction is lw

Behaviour:
- Reset and bubble value: EVALID=0, EALUC=0010, EXA=0, EXB=0, E_DEST=0, E_LOAD=0.
- Latency: one cycle, decode inputs → registered outputs.
- R-type (op 0) funct → EALUC, E_DEST=D_RD:
  - 20→0010, 21→0011, 22→0110, 23→1110
  - 24→0000, 25→0001, 26→1100
  - 2A→0111, 2B→0101, 00→1000, 02→1001
- R-type operands:
  - Arithmetic/logic: EXA=fwd(rs), EXB=fwd(rt).
  - sll/srl: EXA=fwd(rt), EXB={21'b0,D_SHAMT,6'b0}, so shamt lands in EXB[10:6].
- I-type, E_DEST=D_RT, EXA=fwd(rs):
  - 08→0010 sext; 09→0011 sext; 0A→0111 sext; 0B→0101 sext
  - 0C→0000 zext; 0D→0001 zext; 0E→1100 zext
  - 0F (lui)→1111, EXB={16'b0,D_IMM}
  - 23 (lw)→0011 sext, E_LOAD=1
  - 2B (sw)→0011 sext, E_DEST=0
- Any other op/funct is illegal: issued as a bubble, D_STALL not asserted.
- fwd(r):
  - r==0 → 0.
  - Else if M_WE && M_DEST==r → M_VAL.
  - Else if W_WE && W_DEST==r → W_VAL.
  - Else the register-file value.
  - M takes priority over W.
- Load-use hazard:
  - Condition: D_VALID && EVALID && E_LOAD && E_DEST!=0, and E_DEST matches a source the instruction actually reads.
    - rs: all except sll/srl/lui.
    - rt: R-type, and sw.
  - Response: D_STALL=1 and a bubble is loaded into ID/EX.
  - Exactly one bubble per load-use hazard; the next cycle forwards through M.
- Update priority, highest first:
  - RESET
  - FLUSH (bubble; overrides hazard and hold)
  - X_HOLD (registers keep value; D_STALL=1)
  - hazard (bubble)
  - D_VALID (issue)
  - else bubble
- D_STALL equals X_HOLD | hazard, and is forced 0 while FLUSH or RESET.
- Reset mid-stall clears all state; no pending bubble survives.

Optional Feature:
- Macro: ALU_ISSUE_TRACE_EN.
- Defined: on every rising edge where a real instruction issues, a $display prints opcode, EALUC, EXA, EXB and E_DEST in hex.
- Undefined: no simulation output; RTL is otherwise identical.

Test Plan:
- Reset, then idle:
  - RESET=1 two cycles → outputs at bubble values.
  - Release with D_VALID=0 → stays bubble.
- addu with forwarding:
  - D_OP=0, D_FUNCT=21, rs=3, rt=4, D_RSV=5, D_RTV=7; M_WE=1, M_DEST=3, M_VAL=100; W_WE=1, W_DEST=3, W_VAL=9.
  - Next cycle: EALUC=0011, EXA=100, EXB=7, E_DEST=rd, EVALID=1.
- Immediates, shift and $0:
  - andi imm=FFFF → EXB=0000FFFF; addi imm=FFFF → EXB=FFFFFFFF.
  - sll shamt=5, rt=2 (value 1) → EALUC=1000, EXA=1, EXB=00000140.
  - lui imm=1234 → EALUC=1111, EXB=00001234.
  - rs=0 with M_DEST=0, M_WE=1 → EXA=0.
- Load-use:
  - lw to r8, then add r9=r8+r1 → D_STALL=1 one cycle; bubble issued.
  - Next cycle, with M_DEST=8, M_VAL=AA → add issues with EXA=AA.
  - Same sequence with lui r8 dependent → no stall.
- Hold and flush:
  - X_HOLD=1 three cycles → outputs unchanged, D_STALL=1.
  - FLUSH=1 together with X_HOLD and a hazard → bubble next cycle, D_STALL=0.
- Illegal opcode:
  - D_OP=3F, D_VALID=1 → bubble issued, D_STALL=0.

Source files
------------

// File: rtl/alu_issue_stage_if.sv
// Decode-to-execute bundle for alu_issue_stage: decoded fields, forward sources and control in; ID/EX register out.
// master = decode/pipeline control side, slave = the issue stage.
interface alu_issue_stage_if #(parameter int W = 32);
  logic          D_VALID;
  logic [5:0]    D_OP;
  logic [5:0]    D_FUNCT;
  logic [4:0]    D_SHAMT;
  logic [15:0]   D_IMM;
  logic [4:0]    D_RS;
  logic [4:0]    D_RT;
  logic [4:0]    D_RD;
  logic [W-1:0]  D_RSV;
  logic [W-1:0]  D_RTV;
  logic          M_WE;
  logic [4:0]    M_DEST;
  logic [W-1:0]  M_VAL;
  logic          W_WE;
  logic [4:0]    W_DEST;
  logic [W-1:0]  W_VAL;
  logic          X_HOLD;
  logic          FLUSH;
  logic          D_STALL;
  logic          EVALID;
  logic [3:0]    EALUC;
  logic [W-1:0]  EXA;
  logic [W-1:0]  EXB;
  logic [4:0]    E_DEST;
  logic          E_LOAD;

  modport master (
    output D_VALID, D_OP, D_FUNCT, D_SHAMT, D_IMM, D_RS, D_RT, D_RD, D_RSV, D_RTV,
           M_WE, M_DEST, M_VAL, W_WE, W_DEST, W_VAL, X_HOLD, FLUSH,
    input  D_STALL, EVALID, EALUC, EXA, EXB, E_DEST, E_LOAD
  );

  modport slave (
    input  D_VALID, D_OP, D_FUNCT, D_SHAMT, D_IMM, D_RS, D_RT, D_RD, D_RSV, D_RTV,
           M_WE, M_DEST, M_VAL, W_WE, W_DEST, W_VAL, X_HOLD, FLUSH,
    output D_STALL, EVALID, EALUC, EXA, EXB, E_DEST, E_LOAD
  );
endinterface

// File: rtl/alu_issue_stage.sv
// ID/EX issue stage: MIPS decode to ALU control, operand forwarding, load-use bubble, hold and flush.
// Optional macro ALU_ISSUE_TRACE_EN prints every issued instruction (simulation only).
module alu_issue_stage #(
  parameter int W = 32
) (
  input  logic             CLK,
  input  logic             RESET,
  alu_issue_stage_if.slave bus
);

  localparam logic [3:0] ALUC_BUBBLE = 4'b0010;

  typedef enum logic [1:0] {B_RT, B_SHAMT, B_SEXT, B_ZEXT} bsel_e;

  logic          legal;
  logic [3:0]    aluc;
  logic [4:0]    dest;
  logic          is_load;
  logic          rd_rs;
  logic          rd_rt;
  logic          a_from_rt;
  bsel_e         b_sel;

  logic [W-1:0]  fwd_rs;
  logic [W-1:0]  fwd_rt;
  logic          hazard;
  logic          issue;

  logic          evalid_q, evalid_d;
  logic [3:0]    ealuc_q,  ealuc_d;
  logic [W-1:0]  exa_q,    exa_d;
  logic [W-1:0]  exb_q,    exb_d;
  logic [4:0]    edest_q,  edest_d;
  logic          eload_q,  eload_d;

  // Register 0 always reads zero; the younger (EX/MEM) result wins over MEM/WB.
  function automatic logic [W-1:0] fwd(
    input logic [4:0]   r,
    input logic [W-1:0] rf_val,
    input logic         m_we,
    input logic [4:0]   m_dest,
    input logic [W-1:0] m_val,
    input logic         w_we,
    input logic [4:0]   w_dest,
    input logic [W-1:0] w_val
  );
    logic [W-1:0] v;
    if (r == 5'd0)                       v = '0;
    else if (m_we && (m_dest == r))      v = m_val;
    else if (w_we && (w_dest == r))      v = w_val;
    else                                 v = rf_val;
    return v;
  endfunction

  always_comb begin
    legal     = 1'b0;
    aluc      = ALUC_BUBBLE;
    dest      = 5'd0;
    is_load   = 1'b0;
    rd_rs     = 1'b0;
    rd_rt     = 1'b0;
    a_from_rt = 1'b0;
    b_sel     = B_RT;
    if (bus.D_OP == 6'h00) begin
      legal = 1'b1;
      rd_rs = 1'b1;
      rd_rt = 1'b1;
      dest  = bus.D_RD;
      case (bus.D_FUNCT)
        6'h20: aluc = 4'b0010;
        6'h21: aluc = 4'b0011;
        6'h22: aluc = 4'b0110;
        6'h23: aluc = 4'b1110;
        6'h24: aluc = 4'b0000;
        6'h25: aluc = 4'b0001;
        6'h26: aluc = 4'b1100;
        6'h2A: aluc = 4'b0111;
        6'h2B: aluc = 4'b0101;
        6'h00: begin
          aluc      = 4'b1000;
          rd_rs     = 1'b0;
          a_from_rt = 1'b1;
          b_sel     = B_SHAMT;
        end
        6'h02: begin
          aluc      = 4'b1001;
          rd_rs     = 1'b0;
          a_from_rt = 1'b1;
          b_sel     = B_SHAMT;
        end
        default: begin
          legal = 1'b0;
          rd_rs = 1'b0;
          rd_rt = 1'b0;
        end
      endcase
    end else begin
      legal = 1'b1;
      rd_rs = 1'b1;
      dest  = bus.D_RT;
      b_sel = B_SEXT;
      case (bus.D_OP)
        6'h08: aluc = 4'b0010;
        6'h09: aluc = 4'b0011;
        6'h0A: aluc = 4'b0111;
        6'h0B: aluc = 4'b0101;
        6'h0C: begin aluc = 4'b0000; b_sel = B_ZEXT; end
        6'h0D: begin aluc = 4'b0001; b_sel = B_ZEXT; end
        6'h0E: begin aluc = 4'b1100; b_sel = B_ZEXT; end
        6'h0F: begin
          aluc  = 4'b1111;
          b_sel = B_ZEXT;
          rd_rs = 1'b0;
        end
        6'h23: begin aluc = 4'b0011; is_load = 1'b1; end
        6'h2B: begin
          aluc  = 4'b0011;
          dest  = 5'd0;
          rd_rt = 1'b1;
        end
        default: begin
          legal = 1'b0;
          rd_rs = 1'b0;
        end
      endcase
    end
  end

  assign fwd_rs = fwd(bus.D_RS, bus.D_RSV, bus.M_WE, bus.M_DEST, bus.M_VAL,
                      bus.W_WE, bus.W_DEST, bus.W_VAL);
  assign fwd_rt = fwd(bus.D_RT, bus.D_RTV, bus.M_WE, bus.M_DEST, bus.M_VAL,
                      bus.W_WE, bus.W_DEST, bus.W_VAL);

  // A load in EX cannot forward yet; only sources the instruction really reads count.
  assign hazard = bus.D_VALID && evalid_q && eload_q && (edest_q != 5'd0) &&
                  ((rd_rs && (bus.D_RS == edest_q)) || (rd_rt && (bus.D_RT == edest_q)));

  assign issue       = bus.D_VALID && legal && !hazard;
  assign bus.D_STALL = !RESET && !bus.FLUSH && (bus.X_HOLD || hazard);

  always_comb begin
    evalid_d = 1'b0;
    ealuc_d  = ALUC_BUBBLE;
    exa_d    = '0;
    exb_d    = '0;
    edest_d  = 5'd0;
    eload_d  = 1'b0;
    if (issue) begin
      evalid_d = 1'b1;
      ealuc_d  = aluc;
      edest_d  = dest;
      eload_d  = is_load;
      exa_d    = a_from_rt ? fwd_rt : fwd_rs;
      case (b_sel)
        B_SHAMT: exb_d = W'({bus.D_SHAMT, 6'b0});
        B_SEXT:  exb_d = {{(W-16){bus.D_IMM[15]}}, bus.D_IMM};
        B_ZEXT:  exb_d = {{(W-16){1'b0}}, bus.D_IMM};
        default: exb_d = fwd_rt;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET || bus.FLUSH) begin
      evalid_q <= 1'b0;
      ealuc_q  <= ALUC_BUBBLE;
      exa_q    <= '0;
      exb_q    <= '0;
      edest_q  <= 5'd0;
      eload_q  <= 1'b0;
    end else if (!bus.X_HOLD) begin
      evalid_q <= evalid_d;
      ealuc_q  <= ealuc_d;
      exa_q    <= exa_d;
      exb_q    <= exb_d;
      edest_q  <= edest_d;
      eload_q  <= eload_d;
    end
  end

  assign bus.EVALID = evalid_q;
  assign bus.EALUC  = ealuc_q;
  assign bus.EXA    = exa_q;
  assign bus.EXB    = exb_q;
  assign bus.E_DEST = edest_q;
  assign bus.E_LOAD = eload_q;

`ifdef ALU_ISSUE_TRACE_EN
  always @(posedge CLK) begin
    if (!RESET && !bus.FLUSH && !bus.X_HOLD && issue)
      $display("alu_issue: op=%h aluc=%h exa=%h exb=%h dest=%h",
               bus.D_OP, ealuc_d, exa_d, exb_d, edest_d);
  end
`else
`endif

endmodule

// File: tb/tb_alu_issue_stage.sv
// Scoreboard bench for alu_issue_stage: directed plan plus randomized traffic against a table-driven model.
module tb_alu_issue_stage;

  typedef struct {
    bit        rst;
    bit        valid;
    bit [5:0]  op;
    bit [5:0]  funct;
    bit [4:0]  shamt;
    bit [15:0] imm;
    bit [4:0]  rs, rt, rd;
    bit [31:0] rsv, rtv;
    bit        mwe;
    bit [4:0]  mdest;
    bit [31:0] mval;
    bit        wwe;
    bit [4:0]  wdest;
    bit [31:0] wval;
    bit        hold;
    bit        flush;
  } stim_t;

  typedef struct {
    bit        valid;
    bit [3:0]  aluc;
    bit [31:0] a, b;
    bit [4:0]  dest;
    bit        load;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  alu_issue_stage_if bus();

  alu_issue_stage dut (
    .CLK   (clk),
    .RESET (rst),
    .bus   (bus.slave)
  );

  int n_cmp = 0;
  int n_bad = 0;

  bit   stall_q[$];
  exp_t out_q[$];
  exp_t model;

  bit [3:0] r_code [bit [5:0]];
  bit [3:0] i_code [bit [5:0]];
  bit       zext_op[bit [5:0]];

  bit [5:0] r_list[11] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h2A, 6'h2B, 6'h00, 6'h02};
  bit [5:0] i_list[10] = '{6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h0F, 6'h23, 6'h2B};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic exp_t bubble();
    exp_t e;
    e.valid = 1'b0; e.aluc = 4'b0010; e.a = 0; e.b = 0; e.dest = 0; e.load = 1'b0;
    return e;
  endfunction

  function automatic bit [31:0] fwd(input stim_t s, input bit [4:0] r, input bit [31:0] rf);
    if (r == 0) return 0;
    if (s.mwe && s.mdest == r) return s.mval;
    if (s.wwe && s.wdest == r) return s.wval;
    return rf;
  endfunction

  task automatic predict(input stim_t s, input exp_t cur, output exp_t nxt, output bit stall);
    exp_t iss;
    bit legal, shift, rd_rs, rd_rt, hz;
    iss = bubble();
    legal = 0; rd_rs = 0; rd_rt = 0;
    if (s.op == 0) begin
      if (r_code.exists(s.funct)) begin
        legal = 1;
        shift = (s.funct == 6'h00) || (s.funct == 6'h02);
        iss.aluc = r_code[s.funct];
        iss.dest = s.rd;
        iss.a = shift ? fwd(s, s.rt, s.rtv) : fwd(s, s.rs, s.rsv);
        iss.b = shift ? 32'(s.shamt) * 64 : fwd(s, s.rt, s.rtv);
        rd_rs = !shift;
        rd_rt = 1;
      end
    end else if (i_code.exists(s.op)) begin
      legal = 1;
      iss.aluc = i_code[s.op];
      iss.a = fwd(s, s.rs, s.rsv);
      if (s.op == 6'h0F || zext_op.exists(s.op)) iss.b = 32'(s.imm);
      else iss.b = 32'($signed(s.imm));
      iss.dest = (s.op == 6'h2B) ? 5'd0 : s.rt;
      iss.load = (s.op == 6'h23);
      rd_rs = (s.op != 6'h0F);
      rd_rt = (s.op == 6'h2B);
    end
    iss.valid = 1;
    hz = s.valid && cur.valid && cur.load && cur.dest != 0 &&
         ((rd_rs && s.rs == cur.dest) || (rd_rt && s.rt == cur.dest));
    if (s.rst || s.flush) begin nxt = bubble(); stall = 0; end
    else if (s.hold)      begin nxt = cur;      stall = 1; end
    else if (hz)          begin nxt = bubble(); stall = 1; end
    else if (s.valid && legal) begin nxt = iss; stall = 0; end
    else                  begin nxt = bubble(); stall = 0; end
  endtask

  task automatic apply(input stim_t s, output bit stall);
    exp_t n;
    @(negedge clk);
    rst = s.rst;
    bus.D_VALID = s.valid; bus.D_OP = s.op; bus.D_FUNCT = s.funct; bus.D_SHAMT = s.shamt;
    bus.D_IMM = s.imm; bus.D_RS = s.rs; bus.D_RT = s.rt; bus.D_RD = s.rd;
    bus.D_RSV = s.rsv; bus.D_RTV = s.rtv;
    bus.M_WE = s.mwe; bus.M_DEST = s.mdest; bus.M_VAL = s.mval;
    bus.W_WE = s.wwe; bus.W_DEST = s.wdest; bus.W_VAL = s.wval;
    bus.X_HOLD = s.hold; bus.FLUSH = s.flush;
    predict(s, model, n, stall);
    model = n;
    stall_q.push_back(stall);
    out_q.push_back(n);
  endtask

  function automatic stim_t instr(input bit [5:0] op, input bit [5:0] funct,
                                  input bit [4:0] rs, input bit [4:0] rt, input bit [4:0] rd,
                                  input bit [15:0] imm);
    stim_t s;
    s = '{default: 0};
    s.valid = 1; s.op = op; s.funct = funct; s.rs = rs; s.rt = rt; s.rd = rd; s.imm = imm;
    s.rsv = 32'h11110000 | 32'(rs); s.rtv = 32'h22220000 | 32'(rt);
    return s;
  endfunction

  function automatic stim_t rand_stim();
    stim_t s;
    int k;
    s = '{default: 0};
    s.valid = ($urandom_range(0, 99) < 85);
    k = $urandom_range(0, 99);
    if (k < 42) begin
      s.op = 0; s.funct = r_list[$urandom_range(0, 10)];
    end else if (k < 46) begin
      s.op = 0; s.funct = 6'h3F;
    end else if (k < 96) begin
      s.op = i_list[$urandom_range(0, 9)];
      if ($urandom_range(0, 2) == 0) s.op = 6'h23;
    end else begin
      s.op = ($urandom_range(0, 1) == 0) ? 6'h3F : 6'h01;
    end
    s.funct = (s.op == 0) ? s.funct : 6'($urandom);
    s.shamt = 5'($urandom);
    s.imm   = 16'($urandom);
    s.rs = 5'($urandom_range(0, 7)); s.rt = 5'($urandom_range(0, 7)); s.rd = 5'($urandom_range(0, 7));
    s.rsv = $urandom; s.rtv = $urandom;
    s.mwe = $urandom_range(0, 1); s.mdest = 5'($urandom_range(0, 7)); s.mval = $urandom;
    s.wwe = $urandom_range(0, 1); s.wdest = 5'($urandom_range(0, 7)); s.wval = $urandom;
    s.hold  = ($urandom_range(0, 99) < 8);
    s.flush = ($urandom_range(0, 99) < 5);
    s.rst   = ($urandom_range(0, 99) < 2);
    return s;
  endfunction

  // Monitor: D_STALL just after inputs settle, registered outputs just after the edge.
  initial begin
    bit   es;
    exp_t ex;
    forever begin
      @(negedge clk); #2;
      if (stall_q.size() > 0) begin
        es = stall_q.pop_front();
        check("d_stall", 32'(bus.D_STALL), 32'(es));
      end
      @(posedge clk); #1;
      if (out_q.size() > 0) begin
        ex = out_q.pop_front();
        check("evalid", 32'(bus.EVALID), 32'(ex.valid));
        check("ealuc",  32'(bus.EALUC),  32'(ex.aluc));
        check("exa",    bus.EXA,         ex.a);
        check("exb",    bus.EXB,         ex.b);
        check("e_dest", 32'(bus.E_DEST), 32'(ex.dest));
        check("e_load", 32'(bus.E_LOAD), 32'(ex.load));
      end
    end
  end

  initial begin
    stim_t s, prev;
    bit    st, prev_st;

    r_code[6'h20] = 4'b0010; r_code[6'h21] = 4'b0011; r_code[6'h22] = 4'b0110;
    r_code[6'h23] = 4'b1110; r_code[6'h24] = 4'b0000; r_code[6'h25] = 4'b0001;
    r_code[6'h26] = 4'b1100; r_code[6'h2A] = 4'b0111; r_code[6'h2B] = 4'b0101;
    r_code[6'h00] = 4'b1000; r_code[6'h02] = 4'b1001;
    i_code[6'h08] = 4'b0010; i_code[6'h09] = 4'b0011; i_code[6'h0A] = 4'b0111;
    i_code[6'h0B] = 4'b0101; i_code[6'h0C] = 4'b0000; i_code[6'h0D] = 4'b0001;
    i_code[6'h0E] = 4'b1100; i_code[6'h0F] = 4'b1111; i_code[6'h23] = 4'b0011;
    i_code[6'h2B] = 4'b0011;
    zext_op[6'h0C] = 1; zext_op[6'h0D] = 1; zext_op[6'h0E] = 1;
    model = bubble();

    // reset two cycles, then idle
    s = '{default: 0}; s.rst = 1;
    apply(s, st); apply(s, st);
    s.rst = 0;
    apply(s, st); apply(s, st);

    // addu with M and W both matching rs: M wins
    s = instr(6'h00, 6'h21, 5'd3, 5'd4, 5'd6, 16'h0);
    s.rsv = 5; s.rtv = 7;
    s.mwe = 1; s.mdest = 3; s.mval = 100;
    s.wwe = 1; s.wdest = 3; s.wval = 9;
    apply(s, st);

    apply(instr(6'h0C, 6'h00, 5'd1, 5'd2, 5'd0, 16'hFFFF), st);
    apply(instr(6'h08, 6'h00, 5'd1, 5'd2, 5'd0, 16'hFFFF), st);
    s = instr(6'h00, 6'h00, 5'd0, 5'd2, 5'd5, 16'h0); s.shamt = 5; s.rtv = 1;
    apply(s, st);
    s = instr(6'h00, 6'h02, 5'd0, 5'd2, 5'd5, 16'h0); s.shamt = 31;
    apply(s, st);
    apply(instr(6'h0F, 6'h00, 5'd0, 5'd7, 5'd0, 16'h1234), st);
    s = instr(6'h00, 6'h21, 5'd0, 5'd4, 5'd6, 16'h0);
    s.mwe = 1; s.mdest = 0; s.mval = 32'hDEADBEEF;
    apply(s, st);

    // load-use: lw r8, add r9=r8+r1 stalls once, then forwards through M
    apply(instr(6'h23, 6'h00, 5'd1, 5'd8, 5'd0, 16'h0004), st);
    s = instr(6'h00, 6'h20, 5'd8, 5'd1, 5'd9, 16'h0);
    apply(s, st);
    s.mwe = 1; s.mdest = 8; s.mval = 32'hAA;
    apply(s, st);
    // lw then sw reading r8 through rt also stalls; lui "reading" r8 does not
    apply(instr(6'h23, 6'h00, 5'd1, 5'd8, 5'd0, 16'h0), st);
    apply(instr(6'h2B, 6'h00, 5'd2, 5'd8, 5'd0, 16'h0008), st);
    apply(instr(6'h23, 6'h00, 5'd1, 5'd8, 5'd0, 16'h0), st);
    apply(instr(6'h0F, 6'h00, 5'd8, 5'd10, 5'd0, 16'h5555), st);
    // lw to r0 never stalls
    apply(instr(6'h23, 6'h00, 5'd1, 5'd0, 5'd0, 16'h0), st);
    apply(instr(6'h00, 6'h20, 5'd0, 5'd0, 5'd9, 16'h0), st);

    // hold for three cycles, then flush on top of hold and a hazard
    apply(instr(6'h23, 6'h00, 5'd1, 5'd8, 5'd0, 16'h0010), st);
    s = instr(6'h00, 6'h20, 5'd8, 5'd1, 5'd9, 16'h0); s.hold = 1;
    apply(s, st); apply(s, st); apply(s, st);
    s.flush = 1;
    apply(s, st);

    // illegal op and funct
    apply(instr(6'h3F, 6'h00, 5'd1, 5'd2, 5'd3, 16'h0), st);
    apply(instr(6'h00, 6'h3F, 5'd1, 5'd2, 5'd3, 16'h0), st);

    // reset in the middle of a load-use stall
    apply(instr(6'h23, 6'h00, 5'd1, 5'd8, 5'd0, 16'h0), st);
    s = instr(6'h00, 6'h20, 5'd8, 5'd1, 5'd9, 16'h0); s.rst = 1;
    apply(s, st);
    s.rst = 0;
    apply(s, st);

    prev = s; prev_st = 0;
    for (int i = 0; i < 3000; i++) begin
      s = rand_stim();
      if (prev_st && $urandom_range(0, 3) != 0) begin
        s.valid = prev.valid; s.op = prev.op; s.funct = prev.funct; s.shamt = prev.shamt;
        s.imm = prev.imm; s.rs = prev.rs; s.rt = prev.rt; s.rd = prev.rd;
      end
      apply(s, st);
      prev = s; prev_st = st;
    end

    s = '{default: 0};
    apply(s, st); apply(s, st);
    @(posedge clk); #3;
    check("queue_drain", 32'(out_q.size() + stall_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
